imem_server: RTL

- Instruction-memory responder that sits on the far side of the fetch stage's imemraddr/imemrdata/imemrdata1 interface.
- Returns the word at the requested address and the following word, one cycle after the address is presented. This lets fetch see both halves of a 64-bit instruction at once.
- Also contains the program loader: a byte-stream receiver (fed by the UART rx path) that assembles little-endian words and writes them sequentially from word 0.

---
 rtl/imem_server.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/imem_server.sv
// -----------------------------------------------------------------------------
// imem_server
//
// Instruction-memory responder for the fetch stage plus the program loader.
// Each read returns word i and word (i+1) mod depth one cycle after the
// address is presented, so fetch sees both halves of a 64-bit instruction at
// once. Storage is split into an even bank (i[0]=0) and an odd bank (i[0]=1)
// so both words come out of single-read-port memories in the same cycle.
//
// The loader takes a byte stream (UART rx), assembles little-endian words and
// writes them sequentially from word 0.
//
// Ports:
//   clk, rstn     clock; synchronous active-low reset
//   imemraddr     fetch byte address, word index = imemraddr[ADDR_WIDTH+1:2]
//   imemrdata     word i (registered, 1-cycle latency)
//   imemrdata1    word (i+1) mod depth (registered, 1-cycle latency)
//   load_start    begin a load (sampled in IDLE; in DONE returns to IDLE)
//   load_len      number of words to load, sampled with load_start
//   rx_data       program byte
//   rx_valid      rx_data valid
//   rx_ready      byte accepted when rx_valid && rx_ready (high only in LOAD)
//   load_busy     high in LOAD; read outputs are forced to zero meanwhile
//   load_done     high in DONE
//   load_sum      (IMEM_LOAD_CHECKSUM_EN only) mod-256 sum of accepted bytes
//                 since the last IDLE->LOAD transition
//
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN
// -----------------------------------------------------------------------------
module imem_server #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [31:0]           imemraddr,
    output logic [31:0]           imemrdata,
    output logic [31:0]           imemrdata1,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  load_busy,
    output logic                  load_done
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    output logic [7:0]            load_sum
`endif
);

    localparam int BW         = ADDR_WIDTH - 1;
    localparam int BANK_DEPTH = 2 ** BW;
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0] even_mem [BANK_DEPTH];
    logic [31:0] odd_mem  [BANK_DEPTH];

    // ---------------- read path ----------------
    logic [ADDR_WIDTH-1:0] ridx;
    logic [BW-1:0]         odd_raddr;
    logic [BW-1:0]         even_raddr;
    logic [31:0]           even_q, odd_q;
    logic                  sel_q;
    logic                  unused_addr_bits;

    assign ridx       = imemraddr[ADDR_WIDTH+1:2];
    assign odd_raddr  = ridx[ADDR_WIDTH-1:1];
    // (i+1)>>1 in BW bits: wraps to 0 for i = depth-1, giving word 0.
    assign even_raddr = ridx[ADDR_WIDTH-1:1] + BW'(ridx[0]);
    assign unused_addr_bits = ^{imemraddr[31:ADDR_WIDTH+2], imemraddr[1:0]};

    // ---------------- loader datapath ----------------
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   wptr;
    logic [1:0]            bcnt;
    logic [23:0]           wbuf;
    logic                  accept;
    logic                  we;
    logic [31:0]           wdata;
    logic [BW-1:0]         waddr;

    assign accept = rx_valid && (state_q == LOAD);
    assign we     = accept && (bcnt == 2'd3);
    assign wdata  = {rx_data, wbuf};
    assign waddr  = wptr[ADDR_WIDTH-1:1];

    // Memory arrays are not reset so a reset mid-load keeps written words.
    // Reads and writes share the edge; NBA ordering makes reads return the
    // old contents on a same-word collision.
    always_ff @(posedge clk) begin
        if (we && !wptr[0]) even_mem[waddr] <= wdata;
        if (we &&  wptr[0]) odd_mem[waddr]  <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            even_q <= 32'h0;
            odd_q  <= 32'h0;
            sel_q  <= 1'b0;
        end else begin
            even_q <= even_mem[even_raddr];
            odd_q  <= odd_mem[odd_raddr];
            sel_q  <= ridx[0];
        end
    end

    assign imemrdata  = load_busy ? 32'h0 : (sel_q ? odd_q  : even_q);
    assign imemrdata1 = load_busy ? 32'h0 : (sel_q ? even_q : odd_q);

    // ---------------- loader FSM ----------------
    always_comb begin
        state_d   = state_q;
        rx_ready  = 1'b0;
        load_busy = 1'b0;
        load_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) state_d = (load_len != '0) ? LOAD : DONE;
            end
            LOAD: begin
                rx_ready  = 1'b1;
                load_busy = 1'b1;
                if (we && (wptr == len_q - ONE)) state_d = DONE;
            end
            DONE: begin
                load_done = 1'b1;
                if (load_start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            len_q   <= '0;
            wptr    <= '0;
            bcnt    <= 2'd0;
            wbuf    <= 24'h0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            load_sum <= 8'h0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && load_start && load_len != '0) begin
                len_q <= load_len;
                wptr  <= '0;
                bcnt  <= 2'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                load_sum <= 8'h0;
`endif
            end
            if (accept) begin
                // Bytes 0..2 are buffered; byte 3 goes straight into the write.
                case (bcnt)
                    2'd0:    wbuf[7:0]   <= rx_data;
                    2'd1:    wbuf[15:8]  <= rx_data;
                    2'd2:    wbuf[23:16] <= rx_data;
                    default: ;
                endcase
                bcnt <= bcnt + 2'd1;
                if (bcnt == 2'd3) wptr <= wptr + ONE;
`ifdef IMEM_LOAD_CHECKSUM_EN
                load_sum <= load_sum + rx_data;
`endif
            end
        end
    end

endmodule
